// File: rtl/ibuf_pkg.sv
// Shared types and default parameters for the per-warp instruction buffer.
package ibuf_pkg;

  localparam int IBUF_N     = 4;
  localparam int IBUF_DEPTH = 2;
  localparam int IBUF_W     = 32;

  typedef logic [$clog2(IBUF_N)-1:0]   wid_t;
  typedef logic [$clog2(IBUF_DEPTH)-1:0] ptr_t;
  typedef logic [$clog2(IBUF_DEPTH):0]   cnt_t;

  // One extra bit so a full FIFO (count == DEPTH) is representable.
  function automatic int cnt_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ibuf_fifo.sv
// Single-warp FIFO: push at tail, pop at head, flush clears pointers and count.
module ibuf_fifo
  import ibuf_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int W     = IBUF_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [W-1:0]            push_data,
  output logic [W-1:0]            head_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Flush wins over any same-cycle push or pop; the caller gates push/pop on ready/valid.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/warp_ibuffer.sv
// Per-warp instruction buffer feeding the round-robin arbiter; N FIFOs plus
// push/pop decode, grant-indexed output mux and a sticky protocol-error flag.
module warp_ibuffer
  import ibuf_pkg::*;
#(
  parameter int N     = IBUF_N,
  parameter int DEPTH = IBUF_DEPTH,
  parameter int W     = IBUF_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [$clog2(N)-1:0]             in_wid,
  input  logic [W-1:0]                     in_data,
  input  logic [N-1:0]                     flush,
  output logic [N-1:0]                     req,
  input  logic [$clog2(N)-1:0]             grant,
  input  logic                             issue_ready,
  output logic                             out_valid,
  output logic [W-1:0]                     out_data,
  output logic [$clog2(N)-1:0]             out_wid,
  output logic [N*($clog2(DEPTH)+1)-1:0]   occ,
  output logic                             err
);

  localparam int CW = cnt_bits(DEPTH);

  logic [W-1:0]  head [N];
  logic [CW-1:0] cnt  [N];
  logic [N-1:0]  push_vec;
  logic [N-1:0]  pop_vec;
  logic          push_fire;
  logic          pop_fire;
  logic          err_q, err_d;

  // No full-bypass: a full warp refuses a push even when it pops this cycle.
  assign in_ready  = (cnt[in_wid] != CW'(DEPTH));
  assign push_fire = in_valid && in_ready;
  assign out_valid = req[grant];
  assign pop_fire  = issue_ready && out_valid;
  assign out_data  = head[grant];
  assign out_wid   = grant;

  always_comb begin
    push_vec = '0;
    pop_vec  = '0;
    if (push_fire) push_vec[in_wid] = 1'b1;
    if (pop_fire)  pop_vec[grant]   = 1'b1;
  end

  for (genvar i = 0; i < N; i++) begin : g_warp
    ibuf_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_vec[i]),
      .pop       (pop_vec[i]),
      .flush     (flush[i]),
      .push_data (in_data),
      .head_data (head[i]),
      .count     (cnt[i])
    );
    assign req[i]             = (cnt[i] != '0);
    assign occ[i*CW +: CW]    = cnt[i];
  end

  // Sticky: only an issue handshake against an empty granted warp sets it.
  always_comb begin
    err_d = err_q | (issue_ready && !out_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_warp_ibuffer.sv
// Self-checking bench for warp_ibuffer: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_warp_ibuffer;
  import ibuf_pkg::*;

  localparam int N     = IBUF_N;
  localparam int DEPTH = IBUF_DEPTH;
  localparam int W     = IBUF_W;
  localparam int CW    = cnt_bits(DEPTH);

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  wid_t            in_wid;
  logic [W-1:0]    in_data;
  logic [N-1:0]    flush;
  logic [N-1:0]    req;
  wid_t            grant;
  logic            issue_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  wid_t            out_wid;
  logic [N*CW-1:0] occ;
  logic            err;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] mq [N][$];
  logic         merr;

  logic [W-1:0] t3_exp [5] = '{32'h30, 32'h10, 32'h11, 32'h12, 32'h13};
  int           got_wid [$];
  logic [W-1:0] got_dat [$];
  int           last_grant;

  warp_ibuffer #(.N(N), .DEPTH(DEPTH), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_wid      (in_wid),
    .in_data     (in_data),
    .flush       (flush),
    .req         (req),
    .grant       (grant),
    .issue_ready (issue_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_wid     (out_wid),
    .occ         (occ),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: per-warp queues updated from the sampled handshakes.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      merr <= 1'b0;
    end else begin
      bit do_push;
      bit do_pop;
      do_push = in_valid && (mq[in_wid].size() < DEPTH);
      do_pop  = issue_ready && (mq[grant].size() != 0);
      if (issue_ready && mq[grant].size() == 0) merr <= 1'b1;
      for (int i = 0; i < N; i++) begin
        if (flush[i]) begin
          mq[i].delete();
        end else begin
          if (do_pop && int'(grant) == i) void'(mq[i].pop_front());
          if (do_push && int'(in_wid) == i) mq[i].push_back(in_data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("req[%0d]", i), 64'(req[i]), 64'(mq[i].size() != 0));
        check($sformatf("occ[%0d]", i), 64'(occ[i*CW +: CW]), 64'(mq[i].size()));
      end
      check("in_ready", 64'(in_ready), 64'(mq[in_wid].size() != DEPTH));
      check("out_valid", 64'(out_valid), 64'(mq[grant].size() != 0));
      check("out_wid", 64'(out_wid), 64'(grant));
      if (mq[grant].size() != 0) check("out_data", 64'(out_data), 64'(mq[grant][0]));
      check("err", 64'(err), 64'(merr));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int wid, input logic [W-1:0] data);
    in_valid = 1'b1;
    in_wid   = wid_t'(wid);
    in_data  = data;
    cyc();
    in_valid = 1'b0;
  endtask

  function automatic int rr_pick();
    for (int off = 1; off <= N; off++) begin
      int idx;
      idx = (last_grant + off) % N;
      if (mq[idx].size() != 0) return idx;
    end
    return -1;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_wid = '0; in_data = '0;
    flush = '0; grant = '0; issue_ready = 1'b0;
    #2;
    check("rst0_req", 64'(req), 64'h0);
    check("rst0_occ", 64'(occ), 64'h0);
    check("rst0_in_ready", 64'(in_ready), 64'h1);
    check("rst0_out_data", 64'(out_data), 64'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Fill warp 1 past capacity.
    applyStimulus(1, 32'hA0);
    applyStimulus(1, 32'hA1);
    in_valid = 1'b1; in_wid = 2'd1; in_data = 32'hA2; #1;
    check("t2_in_ready_full", 64'(in_ready), 64'h0);
    cyc();
    in_valid = 1'b0; grant = 2'd1; #1;
    check("t2_occ1", 64'(occ[3:2]), 64'h2);
    check("t2_req", 64'(req), 64'h2);
    check("t2_out_data", 64'(out_data), 64'hA0);

    // Full warp with pop in the same cycle still refuses the push.
    in_valid = 1'b1; in_wid = 2'd1; in_data = 32'hA2; issue_ready = 1'b1; #1;
    check("t2b_in_ready", 64'(in_ready), 64'h0);
    cyc();
    in_valid = 1'b0; issue_ready = 1'b0; #1;
    check("t2b_occ1", 64'(occ[3:2]), 64'h1);
    check("t2b_out_data", 64'(out_data), 64'hA1);

    // Push+pop streaming on warp 3 across pointer wrap.
    applyStimulus(3, 32'h30);
    grant = 2'd3;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_wid = 2'd3; in_data = 32'h10 + 32'(k); issue_ready = 1'b1; #1;
      check($sformatf("t3_out_data_%0d", k), 64'(out_data), 64'(t3_exp[k]));
      check($sformatf("t3_occ3_%0d", k), 64'(occ[7:6]), 64'h1);
      cyc();
    end
    in_valid = 1'b0; issue_ready = 1'b0; #1;
    check("t3_tail", 64'(out_data), 64'h14);

    flush = '1;
    cyc();
    flush = '0; #1;
    check("flush_all_occ", 64'(occ), 64'h0);

    // Round-robin drain of warps 0, 2, 3.
    applyStimulus(0, 32'hB0);
    applyStimulus(2, 32'hB2);
    applyStimulus(3, 32'hB3);
    last_grant = N - 1;
    for (int k = 0; k < 6; k++) begin
      int sel;
      sel = rr_pick();
      if (sel < 0) begin
        issue_ready = 1'b0;
        break;
      end
      grant = wid_t'(sel); issue_ready = 1'b1; #1;
      got_wid.push_back(int'(out_wid));
      got_dat.push_back(out_data);
      if (k == 1) check("t4_req_after_pop1", 64'(req), 64'hC);
      last_grant = sel;
      cyc();
    end
    issue_ready = 1'b0; #1;
    check("t4_pop_count", 64'(got_wid.size()), 64'd3);
    check("t4_wid0", 64'(got_wid[0]), 64'd0);
    check("t4_wid1", 64'(got_wid[1]), 64'd2);
    check("t4_wid2", 64'(got_wid[2]), 64'd3);
    check("t4_dat0", 64'(got_dat[0]), 64'hB0);
    check("t4_dat2", 64'(got_dat[2]), 64'hB3);
    check("t4_req_empty", 64'(req), 64'h0);
    check("t4_err", 64'(err), 64'h0);

    // Flush beats same-cycle push and pop on warp 2.
    applyStimulus(2, 32'h22);
    in_valid = 1'b1; in_wid = 2'd2; in_data = 32'h55;
    grant = 2'd2; issue_ready = 1'b1; flush = 4'b0100;
    cyc();
    in_valid = 1'b0; issue_ready = 1'b0; flush = '0; #1;
    check("t5_occ2", 64'(occ[5:4]), 64'h0);
    check("t5_req2", 64'(req[2]), 64'h0);
    check("t5_err", 64'(err), 64'h0);
    applyStimulus(2, 32'h66);
    #1;
    check("t5_head_not_55", 64'(out_data), 64'h66);

    // Pop against an empty warp raises the sticky error.
    grant = 2'd1; issue_ready = 1'b1; #1;
    check("t6_out_valid", 64'(out_valid), 64'h0);
    cyc();
    issue_ready = 1'b0; #1;
    check("t6_err", 64'(err), 64'h1);
    check("t6_occ", 64'(occ), 64'h10);
    cyc(); cyc(); cyc();
    check("t6_err_sticky", 64'(err), 64'h1);

    // Asynchronous reset with warps 0 and 2 occupied.
    applyStimulus(0, 32'h77);
    grant = 2'd0;
    #3;
    rst = 1'b1;
    #1;
    check("t1_req", 64'(req), 64'h0);
    check("t1_occ", 64'(occ), 64'h0);
    check("t1_in_ready", 64'(in_ready), 64'h1);
    check("t1_err", 64'(err), 64'h0);
    check("t1_out_data", 64'(out_data), 64'h0);
    #2;
    rst = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
